// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts 1s over 2^WIDTH valid stochastic samples and presents the count on a valid/ready output
module sc_stream_decoder #(
  parameter int WIDTH = 8,
  parameter int CONTINUOUS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stream_in,
  input  logic             stream_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   value,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  localparam logic [WIDTH:0] WIN = (WIDTH+1)'(1) << WIDTH;
  state_t state_q;
  logic [WIDTH:0] ones_q, samp_q, ones_d, samp_d;
  logic hs, last;
  assign ones_d = ones_q + {{WIDTH{1'b0}}, stream_in};
  assign samp_d = samp_q + (WIDTH+1)'(1);
  assign hs = out_valid && out_ready;
  assign last = stream_valid && samp_d == WIN;
  assign busy = state_q == COUNT;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ones_q <= '0;
      samp_q <= '0;
      value <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (hs) out_valid <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= COUNT;
          ones_q <= '0;
          samp_q <= '0;
        end
        COUNT: if (last) begin
          value <= ones_d;
          out_valid <= 1'b1;
          ones_q <= '0;
          samp_q <= '0;
          if (CONTINUOUS == 0) state_q <= HOLD;
          else if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (stream_valid) begin
          ones_q <= ones_d;
          samp_q <= samp_d;
        end
        HOLD: if (hs) begin
          state_q <= start ? COUNT : IDLE;
          ones_q <= '0;
          samp_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Converts a stochastic bitstream back to binary by counting 1s over a fixed window of 2^WIDTH valid samples.
- Sits downstream of the stochastic dot-product / adder outputs.
- Its stream_in/stream_valid pair connects directly to a producer's result/valid pair.
- The finished count is presented on a valid/ready output handshake for binary-domain logic.

Parameters:
- WIDTH, 8, log2 of window length; window = 2^WIDTH samples; value range 0..2^WIDTH.
- CONTINUOUS, 0, 0 = one window per start pulse; 1 = back-to-back windows after the first start.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- start  input  1  single-cycle request to begin a window; honoured only in IDLE (or as defined under HOLD).
- stream_in  input  1  stochastic bit.
- stream_valid  input  1  stream_in is a valid sample this cycle.
- out_ready  input  1  consumer accepts value.
- value  output  WIDTH+1  count of 1s in the completed window.
- out_valid  output  1  value is valid; held until accepted.
- busy  output  1  state is COUNT.
- overrun  output  1  sticky; a result was overwritten before acceptance (CONTINUOUS=1 only).

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE.
  - value=0, out_valid=0, busy=0, overrun=0.
  - Internal ones_cnt=0, sample_cnt=0.
  - Reset mid-window discards the partial count; a held unaccepted result is lost.
- Counters:
  - ones_cnt is WIDTH+1 bits, so it cannot overflow: max 2^WIDTH.
  - sample_cnt is WIDTH+1 bits; the window ends when sample_cnt reaches 2^WIDTH.
- IDLE:
  - stream_valid is ignored.
  - start=1 -> COUNT; ones_cnt and sample_cnt cleared.
  - The first sample may arrive the cycle after start.
- COUNT (busy=1):
  - Each cycle with stream_valid=1: sample_cnt+=1, ones_cnt+=stream_in.
  - Cycles with stream_valid=0 change nothing.
  - start is ignored.
  - On the cycle that accepts the 2^WIDTH-th sample: value <= ones_cnt+stream_in and out_valid <= 1, both visible the next cycle.
  - Latency: last sample edge -> out_valid high 1 cycle later.
  - CONTINUOUS=0: -> HOLD.
  - CONTINUOUS=1: stay in COUNT with counters cleared, so the next cycle's valid sample is sample 1 of the next window. No samples are dropped.
- HOLD (CONTINUOUS=0 only):
  - value and out_valid are stable until out_valid & out_ready.
  - On handshake: out_valid <= 0. If start=1 in the same cycle -> COUNT with counters cleared; otherwise -> IDLE.
  - start without handshake is ignored.
  - stream_valid is ignored.
- Output handshake (both modes):
  - Transfer occurs when out_valid & out_ready at a clk edge; out_valid drops next cycle unless a new result is loaded on that same edge.
  - out_ready while out_valid=0 has no effect.
- CONTINUOUS=1 collision:
  - Window completes while out_valid=1 and no handshake this cycle: value is overwritten, out_valid stays 1, overrun <= 1 (sticky until reset).
  - Window completes on the same edge as a handshake: new value loaded, out_valid stays 1, no overrun.
- Value encoding: value/2^WIDTH is the decoded probability. An all-1s window yields exactly 2^WIDTH (MSB set, others 0).

Test Plan:
- WIDTH=4: start, then 16 consecutive valid cycles with stream_in=1, out_ready=1 -> value=16 (5'b10000), out_valid high exactly 1 cycle, one cycle after the 16th sample; back to IDLE, busy=0.
- WIDTH=4: alternating 1,0 for 16 valid samples with stream_valid low on every 3rd cycle (gap cycles stream_in=1) -> value=8; gap bits not counted; completion tied to the 16th valid sample.
- WIDTH=4, CONTINUOUS=0: all-0 window with out_ready held low 5 cycles and start pulsed during HOLD -> value=0 and out_valid held stable 5 cycles. Start is ignored. On ready=1 with start=1 -> COUNT entered the next cycle.
- WIDTH=4, CONTINUOUS=1: 48 valid samples (window1 all 1s, window2 four 1s, window3 zero 1s), out_ready=1 -> values 16, 4, 0, each completed one cycle after its last sample; overrun=0.
- Same as previous with out_ready=0 throughout -> after window2 completes value=4, overrun=1; after window3 value=0, overrun remains 1, out_valid remains 1.
- Reset mid-window: after 7 valid 1s, rst=0 for one cycle -> next cycle all outputs 0, state IDLE. New start plus 16 samples (three 1s) -> value=3, with no residue from the aborted window.
